uart_tx_arbiter: RTL

//  Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ requesters.
//  It accepts one byte at a time from the winning requester and issues it to the UART TX as a

---
 rtl/uart_tx_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers.
// Grants in IDLE, pulses Data_Valid once, then waits for the UART busy flag to rise and fall, plus an optional idle gap.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int GAP_CYCLES   = 2,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tx_p_data,
  output logic                        tx_data_valid,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        arb_busy,
  output logic                        timeout_err
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = IW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SW-1:0] REQ_COUNT  = SW'(NUM_REQ);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic [SW-1:0]   sum;
  logic            found;
  logic            grant;
  logic [TW-1:0]   timer;
  logic [GW-1:0]   gap_cnt;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= REQ_COUNT) sum = sum - REQ_COUNT;
      if (!found && req_valid[sum[IW-1:0]]) begin
        found = 1'b1;
        win   = sum[IW-1:0];
      end
    end
  end

  // A foreign frame holding tx_busy blocks new grants.
  assign grant = (state == IDLE) && !tx_busy && found;

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    tx_data_valid = 1'b0;
    timeout_err   = 1'b0;
    arb_busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = ISSUE;
          if (RST) req_ready = NUM_REQ'(1) << win;
        end
      end
      ISSUE: begin
        tx_data_valid = 1'b1;
        state_nxt     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (timer == TIMER_LAST) begin
          timeout_err = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      timer     <= '0;
      gap_cnt   <= '0;
      tx_p_data <= '0;
      grant_id  <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        tx_p_data <= req_data[win*DATA_W +: DATA_W];
        grant_id  <= win;
        rr_ptr    <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
      if (state == ISSUE)
        timer <= '0;
      else if (state == WAIT_BUSY && !tx_busy)
        timer <= timer + 1'b1;
      if (state == WAIT_DONE)
        gap_cnt <= '0;
      else if (state == GAP)
        gap_cnt <= gap_cnt + 1'b1;
    end
  end

endmodule
